// File: rtl/boot_run_sequencer.sv
`timescale 1ns/1ps
// boot_run_sequencer
//
// Loads a program image into instruction memory and a data image into data
// memory from a host beat stream, then enables the CPU for a fixed number of
// cycles and reports completion.
//
// Phase order: IDLE -> LOAD_I -> LOAD_D -> RUN -> DONE. RUN is skipped when
// run_cycles is 0. DONE waits for the next start.
//
// Handshake: load_valid/load_ready follow strict valid/ready semantics. A beat
// transfers on a rising clk edge where both are 1. The host must hold
// load_data/load_last stable while load_valid is 1 and the beat has not
// transferred. load_ready depends only on state, never on load_valid.
//
// Ports:
//   clk, arst_n             clock (rising edge); asynchronous active-low reset
//   start                   begin a load; sampled only in IDLE or DONE
//   abort                   return to IDLE from any state; overrides all else
//   load_valid/ready        host beat handshake
//   load_data/load_last     beat payload; load_last ends the current phase
//   run_cycles              CPU run length; latched on exit from LOAD_D
//   addr_ext/wen_ext/wdata_ext        instruction-memory write port
//   addr_ext_2/wen_ext_2/wdata_ext_2  data-memory write port
//   enable                  CPU run enable, high only in RUN
//   done                    high only in DONE
//   overflow                sticky: a load phase hit its memory depth
//   state_dbg               current FSM state, for checkers
module boot_run_sequencer #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [63:0] load_data,
  input  logic        load_last,
  input  logic [15:0] run_cycles,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        enable,
  output logic        done,
  output logic        overflow,
  output logic [2:0]  state_dbg
);

  localparam int MAX_WORDS = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
  localparam int CW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_I = 3'd1;
  localparam logic [2:0] S_LOAD_D = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] word_cnt;
  logic [15:0]   run_cnt;
  logic          accept;
  logic          i_full, d_full;
  logic          i_end, d_end;

  assign load_ready = (state == S_LOAD_I) || (state == S_LOAD_D);
  assign enable     = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign state_dbg  = state;

  assign accept = load_valid && load_ready;
  // The beat landing in the last memory word closes its phase even without
  // load_last, so later beats cannot address past the memory.
  assign i_full = (word_cnt == CW'(IMEM_WORDS - 1));
  assign d_full = (word_cnt == CW'(DMEM_WORDS - 1));
  assign i_end  = accept && (load_last || i_full);
  assign d_end  = accept && (load_last || d_full);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD_I;
      S_LOAD_I:       if (i_end) state_nxt = S_LOAD_D;
      S_LOAD_D:       if (d_end) state_nxt = (run_cycles == 16'd0) ? S_DONE : S_RUN;
      // run_cnt holds the cycles left including the current one.
      S_RUN:          if (run_cnt <= 16'd1) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      run_cnt     <= '0;
      overflow    <= 1'b0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
    end else begin
      state     <= state_nxt;
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      if (abort) begin
        // A beat accepted in the abort cycle is dropped; overflow survives
        // so the host can still see why the previous load went wrong.
        word_cnt <= '0;
        run_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              word_cnt <= '0;
              overflow <= 1'b0;
            end
          end
          S_LOAD_I: begin
            if (accept) begin
              wen_ext   <= 1'b1;
              addr_ext  <= 64'(word_cnt) << 2;
              wdata_ext <= load_data[31:0];
              if (i_end) begin
                word_cnt <= '0;
                if (!load_last) overflow <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
          S_LOAD_D: begin
            if (accept) begin
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= 64'(word_cnt) << 3;
              wdata_ext_2 <= load_data;
              if (d_end) begin
                word_cnt <= '0;
                run_cnt  <= run_cycles;
                if (!load_last) overflow <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
          S_RUN: begin
            if (run_cnt != 16'd0) run_cnt <= run_cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_run_sequencer.sv
`timescale 1ns/1ps
module tb_boot_run_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_I = 3'd1;
  localparam logic [2:0] S_LOAD_D = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int DST_NONE = 0;
  localparam int DST_IMEM = 1;
  localparam int DST_DMEM = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [63:0] load_data = '0;
  logic        load_last = 1'b0;
  logic [15:0] run_cycles = '0;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic [63:0] wdata_ext_2;
  logic        enable;
  logic        done;
  logic        overflow;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  boot_run_sequencer #(.IMEM_WORDS(4), .DMEM_WORDS(8)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .run_cycles(run_cycles),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
    .enable(enable), .done(done), .overflow(overflow), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {expected byte address, expected write data}.
  logic [127:0] exp_q[$];
  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one beat for one cycle, then check the write it must cause.
  task automatic beat(input logic [63:0] d, input logic last, input int dst,
                      input logic [63:0] addr);
    logic [127:0] e;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    if (dst == DST_IMEM) exp_q.push_back({addr, 32'h0, d[31:0]});
    if (dst == DST_DMEM) exp_q.push_back({addr, d});
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (dst == DST_IMEM) begin
      e = exp_q.pop_front();
      check("imem_wen", {63'b0, wen_ext}, 64'd1);
      check("imem_addr", addr_ext, e[127:64]);
      check("imem_data", {32'b0, wdata_ext}, e[63:0]);
      check("dmem_wen_quiet", {63'b0, wen_ext_2}, 64'd0);
    end else if (dst == DST_DMEM) begin
      e = exp_q.pop_front();
      check("dmem_wen", {63'b0, wen_ext_2}, 64'd1);
      check("dmem_addr", addr_ext_2, e[127:64]);
      check("dmem_data", wdata_ext_2, e[63:0]);
      check("imem_wen_quiet", {63'b0, wen_ext}, 64'd0);
    end else begin
      check("no_wen_i", {63'b0, wen_ext}, 64'd0);
      check("no_wen_d", {63'b0, wen_ext_2}, 64'd0);
    end
  endtask

  // Step until done, counting samples with enable high. Bounded.
  task automatic run_until_done(input int budget, output int en_seen);
    int n;
    n = 0;
    en_seen = 0;
    while (done !== 1'b1 && n < budget) begin
      if (enable === 1'b1) en_seen++;
      step();
      n++;
    end
    check("done_reached", {63'b0, done}, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_i"},  addr_ext, 64'd0);
    check({tag, "_wen_i"},   {63'b0, wen_ext}, 64'd0);
    check({tag, "_data_i"},  {32'b0, wdata_ext}, 64'd0);
    check({tag, "_addr_d"},  addr_ext_2, 64'd0);
    check({tag, "_wen_d"},   {63'b0, wen_ext_2}, 64'd0);
    check({tag, "_data_d"},  wdata_ext_2, 64'd0);
    check({tag, "_ready"},   {63'b0, load_ready}, 64'd0);
    check({tag, "_enable"},  {63'b0, enable}, 64'd0);
    check({tag, "_done"},    {63'b0, done}, 64'd0);
    check({tag, "_ovf"},     {63'b0, overflow}, 64'd0);
    check({tag, "_state"},   {61'b0, state_dbg}, {61'b0, S_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int en;

    // Reset state, and no spontaneous start after release.
    step();
    step();
    check_all_zero("reset");
    arst_n = 1'b1;
    step();
    step();
    check("post_reset_state", {61'b0, state_dbg}, {61'b0, S_IDLE});
    check("post_reset_ready", {63'b0, load_ready}, 64'd0);

    // Basic boot: 3 imem beats, 2 dmem beats, 10 run cycles.
    pulse_start();
    check("t1_state_li", {61'b0, state_dbg}, {61'b0, S_LOAD_I});
    check("t1_ready", {63'b0, load_ready}, 64'd1);
    beat({32'hdeadbeef, 32'h13},  1'b0, DST_IMEM, 64'd0);
    beat({32'hcafef00d, 32'h93},  1'b0, DST_IMEM, 64'd4);
    beat({32'h01234567, 32'h113}, 1'b1, DST_IMEM, 64'd8);
    check("t1_state_ld", {61'b0, state_dbg}, {61'b0, S_LOAD_D});
    run_cycles = 16'd10;
    beat(64'h1111_2222_3333_4444, 1'b0, DST_DMEM, 64'd0);
    beat(64'h5555_6666_7777_8888, 1'b1, DST_DMEM, 64'd8);
    check("t1_state_run", {61'b0, state_dbg}, {61'b0, S_RUN});
    run_until_done(40, en);
    check("t1_enable_cycles", 64'(en), 64'd10);
    check("t1_enable_off", {63'b0, enable}, 64'd0);
    check("t1_ovf", {63'b0, overflow}, 64'd0);
    step();
    check("t1_done_level", {63'b0, done}, 64'd1);
    check("t1_addr_hold", addr_ext, 64'd8);

    // run_cycles = 0: straight to DONE, enable never high.
    pulse_start();
    beat(64'h0000_0000_0000_00aa, 1'b1, DST_IMEM, 64'd0);
    run_cycles = 16'd0;
    beat(64'h0000_0000_0000_00bb, 1'b1, DST_DMEM, 64'd0);
    check("t2_state_done", {61'b0, state_dbg}, {61'b0, S_DONE});
    check("t2_enable", {63'b0, enable}, 64'd0);
    check("t2_done", {63'b0, done}, 64'd1);

    // Overflow: IMEM_WORDS=4, beats without last spill into LOAD_D;
    // then a start during RUN is ignored and abort in cycle 5 of 10.
    pulse_start();
    for (int k = 0; k < 4; k++)
      beat(64'h100 + 64'(k), 1'b0, DST_IMEM, 64'(4 * k));
    check("t3_state_ld", {61'b0, state_dbg}, {61'b0, S_LOAD_D});
    check("t3_ovf_set", {63'b0, overflow}, 64'd1);
    beat(64'h204, 1'b0, DST_DMEM, 64'd0);
    beat(64'h205, 1'b0, DST_DMEM, 64'd8);
    run_cycles = 16'd10;
    beat(64'h206, 1'b1, DST_DMEM, 64'd16);
    check("t3_run_c1", {63'b0, enable}, 64'd1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_start_ignored", {61'b0, state_dbg}, {61'b0, S_RUN});
    step();
    step();
    check("t3_run_c5", {63'b0, enable}, 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_abort_enable", {63'b0, enable}, 64'd0);
    check("t3_abort_state", {61'b0, state_dbg}, {61'b0, S_IDLE});
    check("t3_abort_done", {63'b0, done}, 64'd0);
    check("t3_ovf_kept", {63'b0, overflow}, 64'd1);
    step();
    step();
    check("t3_done_stays0", {63'b0, done}, 64'd0);

    // Restart after abort; host toggles valid every cycle.
    pulse_start();
    check("t4_ovf_cleared", {63'b0, overflow}, 64'd0);
    check("t4_state_li", {61'b0, state_dbg}, {61'b0, S_LOAD_I});
    beat(64'h51, 1'b0, DST_IMEM, 64'd0);
    step();
    check("t4_strobe_single", {63'b0, wen_ext}, 64'd0);
    check("t4_addr_hold", addr_ext, 64'd0);
    check("t4_data_hold", {32'b0, wdata_ext}, 64'h51);
    beat(64'h52, 1'b0, DST_IMEM, 64'd4);
    step();
    beat(64'h53, 1'b1, DST_IMEM, 64'd8);
    step();
    check("t4_state_ld", {61'b0, state_dbg}, {61'b0, S_LOAD_D});
    run_cycles = 16'd2;
    beat(64'hd1, 1'b0, DST_DMEM, 64'd0);
    step();
    check("t4_dstrobe_single", {63'b0, wen_ext_2}, 64'd0);
    beat(64'hd2, 1'b1, DST_DMEM, 64'd8);
    run_until_done(20, en);
    check("t4_enable_cycles", 64'(en), 64'd2);

    // Abort in the same cycle as an accepted beat: no write appears.
    pulse_start();
    load_valid = 1'b1;
    load_data  = 64'h77;
    abort      = 1'b1;
    step();
    load_valid = 1'b0;
    abort      = 1'b0;
    check("t5_wen_suppressed", {63'b0, wen_ext}, 64'd0);
    check("t5_state", {61'b0, state_dbg}, {61'b0, S_IDLE});

    // Asynchronous reset in the middle of LOAD_I.
    pulse_start();
    beat(64'h61, 1'b0, DST_IMEM, 64'd0);
    beat(64'h62, 1'b0, DST_IMEM, 64'd4);
    #2;
    arst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    step();
    arst_n = 1'b1;
    step();
    check("t6_idle_after", {61'b0, state_dbg}, {61'b0, S_IDLE});
    check("t6_ready_after", {63'b0, load_ready}, 64'd0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
